// File: rtl/vx_perf_event_ctrs_pkg.sv
// Shared constants for the performance event counters: channel indices and default channel count.
package vx_perf_event_ctrs_pkg;

  localparam int PERF_EVT_LOADS      = 0;
  localparam int PERF_EVT_STORES     = 1;
  localparam int PERF_EVT_BRANCHES   = 2;
  localparam int PERF_EVT_IBF_STALLS = 3;
  localparam int PERF_EVT_SCB_STALLS = 4;
  localparam int PERF_EVT_LSU_STALLS = 5;
  localparam int PERF_EVT_CSR_STALLS = 6;
  localparam int PERF_EVT_ALU_STALLS = 7;
  localparam int PERF_EVT_FPU_STALLS = 8;
  localparam int PERF_EVT_GPU_STALLS = 9;

  localparam int PERF_NUM_EVENTS = PERF_EVT_GPU_STALLS + 1;

endpackage

// File: rtl/vx_perf_event_ctrs_ctr_cell.sv
// One live event counter with sticky overflow; wraps by default, saturates when
// PERF_CTR_SATURATE_EN is defined. Updates one cycle after inputs, no backpressure.
module vx_perf_event_ctrs_ctr_cell #(
  parameter int CTR_BITS = 44,
  parameter int INC_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [INC_BITS-1:0] inc,
  output logic [CTR_BITS-1:0] count,
  output logic                ovf
);

  // One extra bit captures the carry out of the counter width.
  logic [CTR_BITS:0] sum;
  assign sum = {1'b0, count} + {{(CTR_BITS + 1 - INC_BITS){1'b0}}, inc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (enable) begin
      if (sum[CTR_BITS]) begin
        ovf <= 1'b1;
      end
`ifdef PERF_CTR_SATURATE_EN
      count <= sum[CTR_BITS] ? {CTR_BITS{1'b1}} : sum[CTR_BITS-1:0];
`else
      count <= sum[CTR_BITS-1:0];
`endif
    end
  end

endmodule

// File: rtl/vx_perf_event_ctrs.sv
// Per-channel event counters with a snapshot bank read over a valid/ready port (1-cycle
// response latency, response held until accepted). PERF_CTR_SATURATE_EN selects saturation.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_perf_event_ctrs
  import vx_perf_event_ctrs_pkg::*;
#(
  parameter int NUM_EVENTS = PERF_NUM_EVENTS,
  parameter int CTR_BITS   = `PERF_CTR_BITS,
  parameter int INC_BITS   = 4,
  localparam int IDX_BITS  = $clog2(NUM_EVENTS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clear,
  input  logic                           snap,
  input  logic [NUM_EVENTS*INC_BITS-1:0] evt_inc,
  input  logic                           rd_req_valid,
  input  logic [IDX_BITS-1:0]            rd_req_idx,
  output logic                           rd_req_ready,
  output logic                           rd_rsp_valid,
  output logic [CTR_BITS-1:0]            rd_rsp_data,
  output logic                           rd_rsp_err,
  input  logic                           rd_rsp_ready,
  output logic [NUM_EVENTS-1:0]          ovf
);

  logic [CTR_BITS-1:0] live   [NUM_EVENTS];
  logic [CTR_BITS-1:0] shadow [NUM_EVENTS];

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cell
    vx_perf_event_ctrs_ctr_cell #(
      .CTR_BITS (CTR_BITS),
      .INC_BITS (INC_BITS)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (clear),
      .inc    (evt_inc[g*INC_BITS +: INC_BITS]),
      .count  (live[g]),
      .ovf    (ovf[g])
    );
  end

  // Live values are registers, so a snap always sees the value from before this cycle's update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        shadow[i] <= '0;
      end
    end else if (snap) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        shadow[i] <= live[i];
      end
    end
  end

  logic rd_req_fire;
  logic idx_ok;

  assign rd_req_ready = !rd_rsp_valid || rd_rsp_ready;
  assign rd_req_fire  = rd_req_valid && rd_req_ready;
  assign idx_ok       = int'(rd_req_idx) < NUM_EVENTS;

  // Response data is registered at accept time, so later snaps cannot disturb a held response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
      rd_rsp_err   <= 1'b0;
    end else if (rd_req_fire) begin
      rd_rsp_valid <= 1'b1;
      rd_rsp_data  <= idx_ok ? shadow[rd_req_idx] : '0;
      rd_rsp_err   <= !idx_ok;
    end else if (rd_rsp_ready) begin
      rd_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vx_perf_event_ctrs.sv
// Randomized and directed bench for vx_perf_event_ctrs against an arithmetic reference model.
module tb_vx_perf_event_ctrs;

  localparam int NE   = 10;
  localparam int CB   = 8;
  localparam int IB   = 4;
  localparam int MAXV = (1 << CB) - 1;
`ifdef PERF_CTR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             clear;
  logic             snap;
  logic [NE*IB-1:0] evt_inc;
  logic             rd_req_valid;
  logic [3:0]       rd_req_idx;
  logic             rd_req_ready;
  logic             rd_rsp_valid;
  logic [CB-1:0]    rd_rsp_data;
  logic             rd_rsp_err;
  logic             rd_rsp_ready;
  logic [NE-1:0]    ovf;

  vx_perf_event_ctrs #(
    .NUM_EVENTS (NE),
    .CTR_BITS   (CB),
    .INC_BITS   (IB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .snap         (snap),
    .evt_inc      (evt_inc),
    .rd_req_valid (rd_req_valid),
    .rd_req_idx   (rd_req_idx),
    .rd_req_ready (rd_req_ready),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_err   (rd_rsp_err),
    .rd_rsp_ready (rd_rsp_ready),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers per channel plus the one outstanding response.
  int m_live   [NE];
  int m_shadow [NE];
  bit m_ovf    [NE];
  bit m_vld;
  int m_dat;
  bit m_err;

  int nerr = 0;
  int nchk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [NE-1:0] m_ovf_vec();
    logic [NE-1:0] v;
    for (int i = 0; i < NE; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_live[i] = 0; m_shadow[i] = 0; m_ovf[i] = 0;
    end
    m_vld = 0; m_dat = 0; m_err = 0;
  endtask

  task automatic idle();
    enable = 0; clear = 0; snap = 0; evt_inc = '0;
    rd_req_valid = 0; rd_req_idx = '0; rd_rsp_ready = 1;
  endtask

  task automatic set_inc(input int ch, input int v);
    evt_inc[ch*IB +: IB] = IB'(v);
  endtask

  // One clock: check the handshake, advance the model, then check registered outputs.
  task automatic tick();
    bit rdy;
    int idx;
    int s;
    @(negedge clk);
    rdy = !m_vld || rd_rsp_ready;
    check("rd_req_ready", rd_req_ready, rdy);
    idx = int'(rd_req_idx);
    if (rd_req_valid && rdy) begin
      m_vld = 1;
      m_err = idx >= NE;
      m_dat = m_err ? 0 : m_shadow[idx];
    end else if (rd_rsp_ready) begin
      m_vld = 0;
    end
    for (int i = 0; i < NE; i++) begin
      if (snap) m_shadow[i] = m_live[i];
      if (clear) begin
        m_live[i] = 0;
        m_ovf[i]  = 0;
      end else if (enable) begin
        s = m_live[i] + int'(evt_inc[i*IB +: IB]);
        if (s > MAXV) begin
          m_ovf[i] = 1;
          s = SAT ? MAXV : s % (MAXV + 1);
        end
        m_live[i] = s;
      end
    end
    @(posedge clk);
    #1;
    check("rd_rsp_valid", rd_rsp_valid, m_vld);
    if (m_vld) begin
      check("rd_rsp_data", rd_rsp_data, m_dat);
      check("rd_rsp_err", rd_rsp_err, m_err);
    end
    check("ovf", ovf, m_ovf_vec());
  endtask

  task automatic read_chk(input string tag, input int idx, input int exp_dat, input bit exp_err);
    rd_req_valid = 1; rd_req_idx = 4'(idx); rd_rsp_ready = 1;
    tick();
    check({tag, "_vld"}, rd_rsp_valid, 1);
    check({tag, "_dat"}, rd_rsp_data, exp_dat);
    check({tag, "_err"}, rd_rsp_err, exp_err);
    rd_req_valid = 0;
    tick();
  endtask

  initial begin
    int cnt;
    idle();
    model_reset();
    reset = 1;
    @(posedge clk);
    #1;
    check("rst_vld", rd_rsp_valid, 0);
    check("rst_dat", rd_rsp_data, 0);
    check("rst_err", rd_rsp_err, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rdy", rd_req_ready, 1);
    reset = 0;

    // Ten cycles of +3 on channel 0.
    enable = 1; set_inc(0, 3);
    repeat (10) tick();
    enable = 0; evt_inc = '0; snap = 1;
    tick();
    snap = 0;
    read_chk("acc30", 0, 30, 0);

    // Channel 1 driven to 254, then +4 crosses the top.
    clear = 1; tick(); clear = 0;
    enable = 1; set_inc(1, 15);
    repeat (16) tick();
    set_inc(1, 14); tick();
    check("pre_wrap_ovf", ovf[1], 0);
    set_inc(1, 4); tick();
    enable = 0; evt_inc = '0;
    check("wrap_ovf", ovf[1], 1);
    snap = 1; tick(); snap = 0;
    read_chk("wrap", 1, SAT ? 255 : 2, 0);

    // Clear and snap together at 17 with +5 pending.
    clear = 1; tick(); clear = 0;
    enable = 1; set_inc(2, 15); tick();
    set_inc(2, 2); tick();
    clear = 1; snap = 1; set_inc(2, 5); tick();
    clear = 0; snap = 0; enable = 0; evt_inc = '0;
    check("clr_snap_ovf", ovf, 0);
    read_chk("clr_snap_shadow", 2, 17, 0);
    snap = 1; tick(); snap = 0;
    read_chk("clr_snap_live", 2, 0, 0);

    // Backpressure stall, snap during the stall, then four back-to-back reads.
    enable = 1;
    for (int i = 0; i < NE; i++) set_inc(i, i + 1);
    repeat (3) tick();
    enable = 0; evt_inc = '0; snap = 1; tick(); snap = 0;
    rd_req_valid = 1; rd_req_idx = 4'd3; tick();
    rd_req_valid = 0; rd_rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      enable = (k == 1); snap = (k == 1); set_inc(3, 7);
      tick();
      check("stall_rdy", rd_req_ready, 0);
      check("stall_dat", rd_rsp_data, 12);
    end
    enable = 0; snap = 0; evt_inc = '0;
    rd_rsp_ready = 1; rd_req_valid = 1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      rd_req_idx = 4'(k);
      tick();
      if (rd_rsp_valid) cnt++;
    end
    check("b2b_count", cnt, 4);
    rd_req_valid = 0; tick();

    // Out-of-range indices.
    read_chk("idx_ne", NE, 0, 1);
    read_chk("idx_max", 15, 0, 1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      enable = $urandom_range(0, 3) != 0;
      clear  = $urandom_range(0, 31) == 0;
      snap   = $urandom_range(0, 7) == 0;
      for (int i = 0; i < NE; i++) set_inc(i, $urandom_range(0, 15));
      rd_req_valid = $urandom_range(0, 1) != 0;
      rd_req_idx   = 4'($urandom_range(0, 15));
      rd_rsp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    idle(); tick();

    // Async reset while a response is held.
    enable = 1; set_inc(9, 15);
    repeat (20) tick();
    enable = 0; evt_inc = '0; snap = 1; tick(); snap = 0;
    check("pre_rst_ovf", ovf[9], 1);
    rd_req_valid = 1; rd_req_idx = 4'd9; rd_rsp_ready = 0; tick();
    rd_req_valid = 0;
    check("pre_rst_vld", rd_rsp_valid, 1);
    #3 reset = 1;
    #1;
    check("arst_vld", rd_rsp_valid, 0);
    check("arst_dat", rd_rsp_data, 0);
    check("arst_err", rd_rsp_err, 0);
    check("arst_ovf", ovf, 0);
    check("arst_rdy", rd_req_ready, 1);
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    rd_rsp_ready = 1;
    repeat (3) tick();
    snap = 1; tick(); snap = 0;
    read_chk("post_rst", 9, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
